// File: rtl/mem_copy_master_if.sv
// Memory bus between mem_copy_master and its word-addressed responder.
// Commands: M_READ 7'b1100000, M_WRITE 7'b1110000, M_NONE 7'b1010000.
// Reads have one cycle of synchronous latency at the responder.
interface mem_copy_master_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [6:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        output mem_cmd,
        output mem_addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  mem_cmd,
        input  mem_addr,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/mem_copy_master.sv
// mem_copy_master: copies `length` words from src_addr to dst_addr over a
// simple synchronous memory bus. Each word takes three cycles:
// RD_REQ (issue read), RD_CAP (capture data), WR (write it back out).
// All outputs are registered.
// Optional feature: define MEM_COPY_CHECKSUM_EN to accumulate a running
// modulo-2^DATA_W sum of the words read; otherwise checksum is tied to 0.
module mem_copy_master #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    mem_copy_master_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [6:0] M_READ  = 7'b1100000;
    localparam logic [6:0] M_WRITE = 7'b1110000;
    localparam logic [6:0] M_NONE  = 7'b1010000;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_CAP,
        WR,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic              abort_seen;
    logic [6:0]        mem_cmd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              busy_q;
    logic              done_q;
    logic [LEN_W-1:0]  words_q;
    logic [LEN_W-1:0]  words_next;

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;
`endif

    // Word count after the write in flight completes; drives the
    // end-of-copy test and the next read address.
    always_comb begin
        words_next = words_q + LEN_W'(1);
    end

    // Copy sequencer: state, bus outputs and status all update together so
    // every output is a plain register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            abort_seen <= 1'b0;
            mem_cmd_q  <= M_NONE;
            mem_addr_q <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            words_q    <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_q     <= 1'b0;
                    // start takes priority; a concurrent abort is dropped
                    abort_seen <= 1'b0;
                    if (start) begin
                        busy_q  <= 1'b1;
                        words_q <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
                        csum_q  <= '0;
`endif
                        if (length != '0) begin
                            src_q      <= src_addr;
                            dst_q      <= dst_addr;
                            len_q      <= length;
                            mem_cmd_q  <= M_READ;
                            mem_addr_q <= src_addr;
                            state      <= RD_REQ;
                        end else begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end

                RD_REQ: begin
                    if (abort) begin
                        abort_seen <= 1'b1;
                    end
                    state <= RD_CAP;
                end

                RD_CAP: begin
                    if (abort) begin
                        abort_seen <= 1'b1;
                    end
                    wdata_q    <= bus.read_data;
`ifdef MEM_COPY_CHECKSUM_EN
                    csum_q     <= csum_q + bus.read_data;
`endif
                    mem_cmd_q  <= M_WRITE;
                    mem_addr_q <= dst_q + ADDR_W'(words_q);
                    state      <= WR;
                end

                WR: begin
                    words_q <= words_next;
                    if (words_next == len_q || abort || abort_seen) begin
                        mem_cmd_q  <= M_NONE;
                        done_q     <= 1'b1;
                        abort_seen <= 1'b0;
                        state      <= DONE;
                    end else begin
                        mem_cmd_q  <= M_READ;
                        mem_addr_q <= src_q + ADDR_W'(words_next);
                        state      <= RD_REQ;
                    end
                end

                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    mem_cmd_q <= M_NONE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_cmd    = mem_cmd_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.write_data = wdata_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign words_done     = words_q;

`ifdef MEM_COPY_CHECKSUM_EN
    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master with a one-cycle-latency RAM model.
// Checksum expectations follow MEM_COPY_CHECKSUM_EN.
module tb_mem_copy_master;

    localparam logic [6:0] M_READ  = 7'b1100000;
    localparam logic [6:0] M_WRITE = 7'b1110000;
    localparam logic [6:0] M_NONE  = 7'b1010000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [8:0]  src_addr;
    logic [8:0]  dst_addr;
    logic [8:0]  length;
    logic        busy;
    logic        done;
    logic [8:0]  words_done;
    logic [15:0] checksum;

    int total = 0;
    int bad   = 0;

    mem_copy_master_if #(.ADDR_W(9), .DATA_W(16)) bus ();

    mem_copy_master #(.ADDR_W(9), .DATA_W(16), .LEN_W(9)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .words_done (words_done),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // RAM responder
    logic [15:0] ram [0:511];
    logic [15:0] rdata = '0;
    assign bus.read_data = rdata;

    always @(posedge clk) begin
        if (bus.mem_cmd == M_WRITE) ram[bus.mem_addr] <= bus.write_data;
        if (bus.mem_cmd == M_READ)  rdata <= ram[bus.mem_addr];
    end

    // Bus monitor
    logic [8:0] rd_q[$];
    logic [8:0] wr_q[$];
    int rd_cycles = 0;
    int wr_cycles = 0;
    logic [6:0] prev_cmd = M_NONE;

    always @(negedge clk) begin
        if (bus.mem_cmd == M_READ) begin
            rd_cycles++;
            if (prev_cmd != M_READ) rd_q.push_back(bus.mem_addr);
        end
        if (bus.mem_cmd == M_WRITE) begin
            wr_cycles++;
            wr_q.push_back(bus.mem_addr);
        end
        prev_cmd = bus.mem_cmd;
    end

    task automatic clear_mon;
        rd_q.delete();
        wr_q.delete();
        rd_cycles = 0;
        wr_cycles = 0;
    endtask

    task automatic start_copy(input logic [8:0] s, input logic [8:0] d, input logic [8:0] n);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit timed_out);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        timed_out = (done !== 1'b1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.mem_cmd !== M_NONE) begin bad++; $display("FAIL rst_cmd got=%b want=%b", bus.mem_cmd, M_NONE); end
        total++; if (bus.mem_addr !== 9'h000) begin bad++; $display("FAIL rst_addr got=%h want=000", bus.mem_addr); end
        total++; if (bus.write_data !== 16'h0000) begin bad++; $display("FAIL rst_wdata got=%h want=0000", bus.write_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (words_done !== 9'd0) begin bad++; $display("FAIL rst_words got=%0d want=0", words_done); end
        total++; if (checksum !== 16'h0000) begin bad++; $display("FAIL rst_csum got=%h want=0000", checksum); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_copy;
        int cyc;
        bit to;
        logic [15:0] exp_d [4];
        logic [15:0] exp_csum;
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
`ifdef MEM_COPY_CHECKSUM_EN
        exp_csum = 16'hAAAA;
`else
        exp_csum = 16'h0000;
`endif
        for (int i = 0; i < 4; i++) begin
            ram[i] = exp_d[i];
            ram[9'h080 + i] = 16'h0000;
        end
        clear_mon();
        start_copy(9'h000, 9'h080, 9'd4);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        wait_done(60, cyc, to);
        total++; if (to) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
        total++; if (cyc != 12) begin bad++; $display("FAIL basic_cycles got=%0d want=12", cyc); end
        total++; if (words_done !== 9'd4) begin bad++; $display("FAIL basic_words got=%0d want=4", words_done); end
        total++; if (checksum !== exp_csum) begin bad++; $display("FAIL basic_csum got=%h want=%h", checksum, exp_csum); end
        total++; if (rd_cycles != 8 || wr_cycles != 4) begin bad++; $display("FAIL basic_buscount got=rd%0d/wr%0d want=rd8/wr4", rd_cycles, wr_cycles); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ram[9'h080 + i] !== exp_d[i]) begin bad++; $display("FAIL basic_ram%0d got=%h want=%h", i, ram[9'h080 + i], exp_d[i]); end
            total++;
            if (wr_q.size() <= i || wr_q[i] !== 9'(9'h080 + i)) begin bad++; $display("FAIL basic_wraddr%0d want=%h", i, 9'(9'h080 + i)); end
            total++;
            if (rd_q.size() <= i || rd_q[i] !== 9'(i)) begin bad++; $display("FAIL basic_rdaddr%0d want=%h", i, 9'(i)); end
        end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_after got=done%b/busy%b want=done0/busy0", done, busy); end
        total++; if (bus.mem_cmd !== M_NONE || bus.mem_addr !== 9'h083) begin bad++; $display("FAIL basic_idlebus got=%b/%h want=%b/083", bus.mem_cmd, bus.mem_addr, M_NONE); end
    endtask

    task automatic test_zero_length;
        clear_mon();
        start_copy(9'h005, 9'h040, 9'd0);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", done); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy got=%b want=1", busy); end
        total++; if (words_done !== 9'd0) begin bad++; $display("FAIL zero_words got=%0d want=0", words_done); end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL zero_after got=done%b/busy%b want=done0/busy0", done, busy); end
        total++; if (rd_cycles != 0 || wr_cycles != 0) begin bad++; $display("FAIL zero_bus got=rd%0d/wr%0d want=rd0/wr0", rd_cycles, wr_cycles); end
    endtask

    task automatic test_wrap;
        int cyc;
        bit to;
        logic [8:0]  exp_r [3];
        logic [15:0] exp_d [3];
        exp_r[0] = 9'h1FE; exp_r[1] = 9'h1FF; exp_r[2] = 9'h000;
        exp_d[0] = 16'hA1A1; exp_d[1] = 16'hB2B2; exp_d[2] = 16'hC3C3;
        for (int i = 0; i < 3; i++) begin
            ram[exp_r[i]] = exp_d[i];
            ram[9'h010 + i] = 16'h0000;
        end
        clear_mon();
        start_copy(9'h1FE, 9'h010, 9'd3);
        wait_done(40, cyc, to);
        total++; if (to || cyc != 9) begin bad++; $display("FAIL wrap_cycles got=%0d want=9", cyc); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (rd_q.size() <= i || rd_q[i] !== exp_r[i]) begin bad++; $display("FAIL wrap_rdaddr%0d want=%h", i, exp_r[i]); end
            total++;
            if (wr_q.size() <= i || wr_q[i] !== 9'(9'h010 + i)) begin bad++; $display("FAIL wrap_wraddr%0d want=%h", i, 9'(9'h010 + i)); end
            total++;
            if (ram[9'h010 + i] !== exp_d[i]) begin bad++; $display("FAIL wrap_ram%0d got=%h want=%h", i, ram[9'h010 + i], exp_d[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int cyc;
        bit to;
        for (int i = 0; i < 8; i++) ram[9'h020 + i] = 16'(16'h5000 + i);
        clear_mon();
        start_copy(9'h020, 9'h0A0, 9'd8);
        repeat (4) @(negedge clk);
        total++; if (bus.mem_cmd !== M_READ || bus.mem_addr !== 9'h021) begin bad++; $display("FAIL abort_rdcap got=%b/%h want=%b/021", bus.mem_cmd, bus.mem_addr, M_READ); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total++; if (bus.mem_cmd !== M_WRITE || bus.mem_addr !== 9'h0A1) begin bad++; $display("FAIL abort_wr got=%b/%h want=%b/0a1", bus.mem_cmd, bus.mem_addr, M_WRITE); end
        wait_done(40, cyc, to);
        total++; if (to || cyc != 1) begin bad++; $display("FAIL abort_done got=%0d want=1", cyc); end
        total++; if (words_done !== 9'd2) begin bad++; $display("FAIL abort_words got=%0d want=2", words_done); end
        total++; if (wr_cycles != 2) begin bad++; $display("FAIL abort_writes got=%0d want=2", wr_cycles); end
        total++; if (ram[9'h0A1] !== 16'h5001) begin bad++; $display("FAIL abort_ram got=%h want=5001", ram[9'h0A1]); end
        @(negedge clk);

        // abort held through IDLE and coincident with start: start wins
        clear_mon();
        abort = 1'b1;
        repeat (2) @(negedge clk);
        start_copy(9'h020, 9'h0B0, 9'd3);
        abort = 1'b0;
        wait_done(40, cyc, to);
        total++; if (to || words_done !== 9'd3) begin bad++; $display("FAIL abort_idle_words got=%0d want=3", words_done); end
        total++; if (wr_cycles != 3) begin bad++; $display("FAIL abort_idle_writes got=%0d want=3", wr_cycles); end
        @(negedge clk);
    endtask

    task automatic test_start_while_busy;
        int cyc;
        bit to;
        // ram[0] holds C3C3 from the wrap test
        clear_mon();
        start_copy(9'h000, 9'h100, 9'd3);
        repeat (2) @(negedge clk);
        src_addr = 9'h1F0; dst_addr = 9'h1C0; length = 9'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(40, cyc, to);
        total++; if (to || words_done !== 9'd3) begin bad++; $display("FAIL busy_start_words got=%0d want=3", words_done); end
        total++; if (wr_q.size() != 3 || wr_q[0] !== 9'h100 || wr_q[2] !== 9'h102) begin bad++; $display("FAIL busy_start_wraddr got=n%0d want=100..102", wr_q.size()); end
        total++; if (rd_q.size() != 3 || rd_q[0] !== 9'h000 || rd_q[2] !== 9'h002) begin bad++; $display("FAIL busy_start_rdaddr got=n%0d want=000..002", rd_q.size()); end
        total++; if (ram[9'h100] !== 16'hC3C3 || ram[9'h102] !== 16'h3333) begin bad++; $display("FAIL busy_start_ram got=%h/%h want=c3c3/3333", ram[9'h100], ram[9'h102]); end
        repeat (4) @(negedge clk);
        total++; if (busy !== 1'b0 || wr_cycles != 3) begin bad++; $display("FAIL busy_start_idle got=busy%b/wr%0d want=busy0/wr3", busy, wr_cycles); end
    endtask

    task automatic test_reset_mid_copy;
        int snap;
        clear_mon();
        start_copy(9'h020, 9'h1A0, 9'd4);
        repeat (5) @(negedge clk);
        total++; if (bus.mem_cmd !== M_WRITE || words_done !== 9'd1) begin bad++; $display("FAIL midrst_pre got=%b/%0d want=%b/1", bus.mem_cmd, words_done, M_WRITE); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (bus.mem_cmd !== M_NONE) begin bad++; $display("FAIL midrst_cmd got=%b want=%b", bus.mem_cmd, M_NONE); end
        total++; if (busy !== 1'b0 || words_done !== 9'd0) begin bad++; $display("FAIL midrst_state got=busy%b/words%0d want=busy0/words0", busy, words_done); end
        snap = wr_cycles;
        repeat (3) @(negedge clk);
        total++; if (wr_cycles != snap || rd_cycles != 4) begin bad++; $display("FAIL midrst_quiet got=wr%0d/rd%0d want=wr%0d/rd4", wr_cycles, rd_cycles, snap); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_checksum_wrap;
        int cyc;
        bit to;
        logic [15:0] exp_csum;
`ifdef MEM_COPY_CHECKSUM_EN
        exp_csum = 16'h0001;
`else
        exp_csum = 16'h0000;
`endif
        ram[9'h030] = 16'hFFFF;
        ram[9'h031] = 16'h0002;
        clear_mon();
        start_copy(9'h030, 9'h130, 9'd2);
        wait_done(30, cyc, to);
        total++; if (to || cyc != 6) begin bad++; $display("FAIL csum_cycles got=%0d want=6", cyc); end
        total++; if (checksum !== exp_csum) begin bad++; $display("FAIL csum_wrap got=%h want=%h", checksum, exp_csum); end
        total++; if (ram[9'h131] !== 16'h0002) begin bad++; $display("FAIL csum_ram got=%h want=0002", ram[9'h131]); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 16'h0000;
        test_reset();
        test_basic_copy();
        test_zero_length();
        test_wrap();
        test_abort();
        test_start_while_busy();
        test_reset_mid_copy();
        test_checksum_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
